// File: rtl/acq_echo_sequencer.sv
// acq_echo_sequencer: multi-echo NMR acquisition train sequencer for the ADC window generator
// Ports: CLK/RESET (async, active-high); START/ABORT control; NUM_ECHOES, PRE_DELAY, WND_LEN,
// ECHO_PERIOD config (latched on accepted START); ACQ_EN monitored from the window generator;
// ACQ_WND/WINGEN_RST drive the generator; BUSY/DONE/CFG_ERR/OVERRUN status; ECHO_IDX, SAMPLE_CNT.
module acq_echo_sequencer #(
    parameter int CNT_WIDTH  = 32,
    parameter int ECHO_WIDTH = 16,
    parameter int SCNT_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  START,
    input  logic                  ABORT,
    input  logic [ECHO_WIDTH-1:0] NUM_ECHOES,
    input  logic [CNT_WIDTH-1:0]  PRE_DELAY,
    input  logic [CNT_WIDTH-1:0]  WND_LEN,
    input  logic [CNT_WIDTH-1:0]  ECHO_PERIOD,
    input  logic                  ACQ_EN,
    output logic                  ACQ_WND,
    output logic                  WINGEN_RST,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  CFG_ERR,
    output logic                  OVERRUN,
    output logic [ECHO_WIDTH-1:0] ECHO_IDX,
    output logic [SCNT_WIDTH-1:0] SAMPLE_CNT
);
    typedef enum logic [2:0] {IDLE, ARM, PRE, WND, GAP, FIN} state_t;
    state_t                state_q;
    logic [CNT_WIDTH-1:0]  cnt_q, pre_q, wnd_q, per_q;
    logic [ECHO_WIDTH-1:0] num_q, idx_q;
    logic [SCNT_WIDTH-1:0] smp_q;
    logic                  acq_wnd_q, wrst_q, busy_q, done_q, cfg_err_q, ovr_q;
    logic                  cnt_zero, cfg_bad, last_win, abort_now, rise, fin;
    logic [ECHO_WIDTH-1:0] idx_d;
    assign cnt_zero  = cnt_q == '0;
    assign cfg_bad   = WND_LEN == '0 || ECHO_PERIOD <= WND_LEN;
    assign last_win  = idx_q == num_q - ECHO_WIDTH'(1);
    assign abort_now = ABORT && state_q != IDLE;
    // A window rises when the arm phase ends with no pre-delay, when the pre-delay
    // expires, or when a gap expires with more windows still to go.
    assign rise = !abort_now && cnt_zero &&
                  ((state_q == ARM && num_q != '0 && pre_q == '0) ||
                   state_q == PRE || (state_q == GAP && !last_win));
    assign fin  = !abort_now && cnt_zero &&
                  ((state_q == ARM && num_q == '0) || (state_q == GAP && last_win));
    assign idx_d = state_q == GAP ? idx_q + ECHO_WIDTH'(1) : '0;
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pre_q     <= '0;
            wnd_q     <= '0;
            per_q     <= '0;
            num_q     <= '0;
            idx_q     <= '0;
            smp_q     <= '0;
            acq_wnd_q <= 1'b0;
            wrst_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            // Saturating sample counter; frozen on an abort edge so it holds its value.
            if (busy_q && ACQ_EN && !abort_now && smp_q != '1)
                smp_q <= smp_q + SCNT_WIDTH'(1);
            if (abort_now) begin
                acq_wnd_q <= 1'b0;
                wrst_q    <= 1'b1;
                busy_q    <= 1'b0;
                state_q   <= IDLE;
            end else if (rise) begin
                acq_wnd_q <= 1'b1;
                wrst_q    <= 1'b0;
                idx_q     <= idx_d;
                cnt_q     <= wnd_q - CNT_WIDTH'(1);
                state_q   <= WND;
                if (ACQ_EN)
                    ovr_q <= 1'b1;
            end else if (fin) begin
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
                wrst_q  <= 1'b0;
                state_q <= FIN;
            end else begin
                case (state_q)
                    IDLE: begin
                        wrst_q <= 1'b0;
                        if (START && cfg_bad)
                            cfg_err_q <= 1'b1;
                        else if (START) begin
                            num_q   <= NUM_ECHOES;
                            pre_q   <= PRE_DELAY;
                            wnd_q   <= WND_LEN;
                            per_q   <= ECHO_PERIOD;
                            busy_q  <= 1'b1;
                            wrst_q  <= 1'b1;
                            smp_q   <= '0;
                            ovr_q   <= 1'b0;
                            idx_q   <= '0;
                            cnt_q   <= CNT_WIDTH'(1);
                            state_q <= ARM;
                        end
                    end
                    ARM: begin
                        if (cnt_zero) begin
                            wrst_q  <= 1'b0;
                            cnt_q   <= pre_q - CNT_WIDTH'(1);
                            state_q <= PRE;
                        end else
                            cnt_q <= cnt_q - CNT_WIDTH'(1);
                    end
                    WND: begin
                        if (cnt_zero) begin
                            acq_wnd_q <= 1'b0;
                            cnt_q     <= per_q - wnd_q - CNT_WIDTH'(1);
                            state_q   <= GAP;
                        end else
                            cnt_q <= cnt_q - CNT_WIDTH'(1);
                    end
                    PRE, GAP: cnt_q <= cnt_q - CNT_WIDTH'(1);
                    FIN:      state_q <= IDLE;
                    default:  state_q <= IDLE;
                endcase
            end
        end
    end
    assign ACQ_WND    = acq_wnd_q;
    assign WINGEN_RST = wrst_q;
    assign BUSY       = busy_q;
    assign DONE       = done_q;
    assign CFG_ERR    = cfg_err_q;
    assign OVERRUN    = ovr_q;
    assign ECHO_IDX   = idx_q;
    assign SAMPLE_CNT = smp_q;
endmodule

// File: tb/tb_acq_echo_sequencer.sv
// tb_acq_echo_sequencer: directed self-checking bench for acq_echo_sequencer
module tb_acq_echo_sequencer;
    logic        CLK = 1'b0, RESET = 1'b1, START = 1'b0, ABORT = 1'b0, ACQ_EN = 1'b0;
    logic [15:0] NUM_ECHOES = '0;
    logic [31:0] PRE_DELAY = '0, WND_LEN = '0, ECHO_PERIOD = '0;
    logic        ACQ_WND, WINGEN_RST, BUSY, DONE, CFG_ERR, OVERRUN;
    logic [15:0] ECHO_IDX;
    logic [31:0] SAMPLE_CNT;
    int          checks = 0, failures = 0;
    acq_echo_sequencer dut (
        .CLK(CLK), .RESET(RESET), .START(START), .ABORT(ABORT),
        .NUM_ECHOES(NUM_ECHOES), .PRE_DELAY(PRE_DELAY), .WND_LEN(WND_LEN),
        .ECHO_PERIOD(ECHO_PERIOD), .ACQ_EN(ACQ_EN), .ACQ_WND(ACQ_WND),
        .WINGEN_RST(WINGEN_RST), .BUSY(BUSY), .DONE(DONE), .CFG_ERR(CFG_ERR),
        .OVERRUN(OVERRUN), .ECHO_IDX(ECHO_IDX), .SAMPLE_CNT(SAMPLE_CNT)
    );
    always #5 CLK = ~CLK;
    task automatic tick;
        @(posedge CLK);
        #1;
    endtask
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    function automatic logic [4:0] status;
        return {ACQ_WND, WINGEN_RST, BUSY, DONE, CFG_ERR};
    endfunction
    // Expected {ACQ_WND,WINGEN_RST,BUSY,DONE,CFG_ERR} after edge e of a train started at edge 0.
    function automatic logic [4:0] exp_vec(input int n, input int p, input int w, input int per, input int e);
        int pe = n == 0 ? 0 : p;
        int t  = e - 2 - pe;
        return {t >= 0 && t < n * per && (t % per) < w, e < 2, e < 2 + pe + n * per,
                e == 2 + pe + n * per, 1'b0};
    endfunction
    task automatic start_train(input int n, input int p, input int w, input int per);
        NUM_ECHOES  = 16'(n);
        PRE_DELAY   = 32'(p);
        WND_LEN     = 32'(w);
        ECHO_PERIOD = 32'(per);
        START = 1'b1;
        tick;
        START = 1'b0;
    endtask
    // mode 0 quiet, 1 ACQ_EN 3 cycles inside each window, 2 ACQ_EN across rise of
    // window 1, 3 config changed and a stray START mid-train
    task automatic run_train(input int n, input int p, input int w, input int per, input int mode);
        int last = 2 + (n == 0 ? 0 : p) + n * per + 2;
        start_train(n, p, w, per);
        if (mode == 3) begin
            NUM_ECHOES = 7; PRE_DELAY = 0; WND_LEN = 1; ECHO_PERIOD = 2;
        end
        for (int e = 0; e <= last; e++) begin
            int t = e - 2 - p;
            chk($sformatf("train n=%0d m=%0d e=%0d", n, mode, e), 64'(status()), 64'(exp_vec(n, p, w, per, e)));
            ACQ_EN = (mode == 1 && t >= 0 && t < n * per && (t % per) < 3) || (mode == 2 && e == 15);
            START  = mode == 3 && e == 10;
            tick;
        end
        ACQ_EN = 1'b0;
        START  = 1'b0;
        chk($sformatf("idx n=%0d m=%0d", n, mode), 64'(ECHO_IDX), n == 0 ? 0 : 64'(n - 1));
        chk($sformatf("smp n=%0d m=%0d", n, mode), 64'(SAMPLE_CNT), mode == 1 ? 64'(3 * n) : mode == 2 ? 1 : 0);
        chk($sformatf("ovr n=%0d m=%0d", n, mode), 64'(OVERRUN), mode == 2 ? 1 : 0);
    endtask
    initial begin
        tick;
        tick;
        RESET = 1'b0;
        tick;
        chk("reset status", 64'({status(), OVERRUN}), 0);
        chk("reset idx", 64'(ECHO_IDX), 0);
        chk("reset smp", 64'(SAMPLE_CNT), 0);
        run_train(3, 4, 5, 10, 0);
        run_train(0, 4, 5, 10, 0);
        run_train(1, 0, 1, 2, 0);
        run_train(3, 4, 5, 10, 1);
        run_train(3, 4, 5, 10, 2);
        run_train(3, 4, 5, 10, 3);
        start_train(3, 4, 0, 10);
        chk("cfg wnd0 pulse", 64'(status()), 64'(5'b00001));
        tick;
        chk("cfg wnd0 clear", 64'(status()), 0);
        start_train(3, 4, 5, 5);
        chk("cfg eq pulse", 64'(status()), 64'(5'b00001));
        tick;
        chk("cfg eq clear", 64'(status()), 0);
        start_train(3, 4, 5, 10);
        repeat (17) tick;
        chk("abort pre wnd", 64'({ACQ_WND, ECHO_IDX}), 64'({1'b1, 16'd1}));
        ABORT = 1'b1;
        START = 1'b1;
        tick;
        ABORT = 1'b0;
        START = 1'b0;
        chk("abort edge", 64'(status()), 64'(5'b01000));
        chk("abort idx", 64'(ECHO_IDX), 1);
        for (int e = 19; e < 40; e++) begin
            tick;
            chk($sformatf("after abort e=%0d", e), 64'(status()), 0);
        end
        NUM_ECHOES = 1; PRE_DELAY = 0; WND_LEN = 1; ECHO_PERIOD = 2;
        ABORT = 1'b1;
        START = 1'b1;
        tick;
        ABORT = 1'b0;
        START = 1'b0;
        chk("idle start+abort e=0", 64'(status()), 64'(exp_vec(1, 0, 1, 2, 0)));
        for (int e = 1; e <= 5; e++) begin
            tick;
            chk($sformatf("idle start+abort e=%0d", e), 64'(status()), 64'(exp_vec(1, 0, 1, 2, e)));
        end
        start_train(3, 4, 5, 10);
        repeat (8) tick;
        chk("pre async wnd", 64'(ACQ_WND), 1);
        #2 RESET = 1'b1;
        #1;
        chk("async reset status", 64'(status()), 0);
        chk("async reset idx", 64'(ECHO_IDX), 0);
        #1 RESET = 1'b0;
        run_train(3, 4, 5, 10, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
